burst_strobe_gen: RTL

Programmable burst strobe generator. After a start request it emits N single-cycle strobes spaced P clocks apart, with a strobe index, then signals completion. It sits directly upstream of the design's counters and accumulators: `strobe` drives their `ena` input, and `index` tags each enabled step. This gives sample-window, dwell and frame sequencing.

---
 rtl/burst_strobe_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/burst_strobe_gen.sv
// Programmable burst strobe generator: after an accepted start, emits N
// single-cycle strobes spaced P clocks apart, each tagged with its ordinal.
module burst_strobe_gen #(
  parameter int PERIOD_WIDTH = 16,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [COUNT_WIDTH-1:0]  num_strobes,
  output logic                    strobe,
  output logic [COUNT_WIDTH-1:0]  index,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]  C_ONE = COUNT_WIDTH'(1);

  state_t                  r_state, w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_timer, w_timer_nxt;
  logic [PERIOD_WIDTH-1:0] r_period, w_period_nxt;
  logic [COUNT_WIDTH-1:0]  r_count, w_count_nxt;
  logic [COUNT_WIDTH-1:0]  r_num, w_num_nxt;
  logic [COUNT_WIDTH-1:0]  r_index, w_index_nxt;
  logic                    r_strobe, w_strobe_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_last;

  assign w_last = (r_count == (r_num - C_ONE));

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_period_nxt = r_period;
    w_count_nxt  = r_count;
    w_num_nxt    = r_num;
    w_index_nxt  = r_index;
    w_strobe_nxt = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start && !abort) begin
          if (num_strobes == '0) begin
            // Empty burst: no strobes, busy never rises, done still pulses.
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt  = S_RUN;
            w_period_nxt = (period == '0) ? P_ONE : period;
            w_num_nxt    = num_strobes;
            w_timer_nxt  = P_ONE;
            w_count_nxt  = '0;
            w_busy_nxt   = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (r_timer == r_period) begin
          w_strobe_nxt = 1'b1;
          w_index_nxt  = r_count;
          w_timer_nxt  = P_ONE;
          if (w_last) begin
            // The last strobe, done and busy falling all share one edge.
            w_state_nxt = S_FINISH;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_count_nxt = r_count + C_ONE;
          end
        end else begin
          w_timer_nxt = r_timer + P_ONE;
        end
      end

      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_period <= '0;
      r_count  <= '0;
      r_num    <= '0;
      r_index  <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_period <= w_period_nxt;
      r_count  <= w_count_nxt;
      r_num    <= w_num_nxt;
      r_index  <= w_index_nxt;
      r_strobe <= w_strobe_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign strobe = r_strobe;
  assign index  = r_index;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
